// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default geometry, FSM states
// and the {push,pop} operation encodings.
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } stack_state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/operand_stack_if.sv
// Control-unit <-> operand stack bundle: op strobes and push data in,
// top/next-on-stack words and status flags out.
interface operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             clear_err;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic             fault;

    modport master (
        output push, pop, data_in, clear_err,
        input  tos, nos, count, empty, full, overflow, underflow, fault
    );

    modport slave (
        input  push, pop, data_in, clear_err,
        output tos, nos, count, empty, full, overflow, underflow, fault
    );
endinterface

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage for the operand stack: one write port and two
// combinational read ports, with the whole array cleared on reset.
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack with stack pointer, boundary checks and a fault FSM
// that freezes the stack on overflow/underflow until clear_err.
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    operand_stack_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    stack_state_t     state_q, state_d;
    logic [CW-1:0]    sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [CW-1:0]    spMinus1;
    logic [CW-1:0]    spMinus2;
    logic [WIDTH-1:0] rdTos;
    logic [WIDTH-1:0] rdNos;
    logic             isEmpty;
    logic             isFull;

    assign spMinus1 = sp_q - CW'(1);
    assign spMinus2 = sp_q - CW'(2);
    assign isEmpty  = (sp_q == '0);
    assign isFull   = (sp_q == CW'(DEPTH));

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (bus.data_in),
        .raddr_a_i (spMinus1[AW-1:0]),
        .raddr_b_i (spMinus2[AW-1:0]),
        .rdata_a_o (rdTos),
        .rdata_b_o (rdNos)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_NORMAL;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Replace (push+pop) rewrites TOS in place, so it stays legal when full.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = sp_q[AW-1:0];
        case (state_q)
            ST_NORMAL: begin
                case ({bus.push, bus.pop})
                    OP_PUSH: begin
                        if (isFull) begin
                            ovf_d   = 1'b1;
                            state_d = ST_FAULT;
                        end else begin
                            we   = 1'b1;
                            sp_d = sp_q + CW'(1);
                        end
                    end
                    OP_POP: begin
                        if (isEmpty) begin
                            unf_d   = 1'b1;
                            state_d = ST_FAULT;
                        end else begin
                            sp_d = spMinus1;
                        end
                    end
                    OP_REPL: begin
                        if (isEmpty) begin
                            unf_d   = 1'b1;
                            state_d = ST_FAULT;
                        end else begin
                            we    = 1'b1;
                            waddr = spMinus1[AW-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            ST_FAULT: begin
                if (bus.clear_err) begin
                    state_d = ST_NORMAL;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    assign bus.tos       = isEmpty ? '0 : rdTos;
    assign bus.nos       = (sp_q < CW'(2)) ? '0 : rdNos;
    assign bus.count     = sp_q;
    assign bus.empty     = isEmpty;
    assign bus.full      = isFull;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: each op is applied for one clock and
// the outputs are compared against hand-computed values shortly after.
module tb_operand_stack;

    logic clk;
    logic reset;
    int   vectorCount;
    int   missCount;

    operand_stack_if #(.WIDTH(8), .DEPTH(16)) bus ();

    operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one op for exactly one rising edge, then return the strobes to idle.
    task automatic applyStimulus(input logic p, input logic q, input logic [7:0] d,
                                 input logic c);
        @(negedge clk);
        bus.push      = p;
        bus.pop       = q;
        bus.data_in   = d;
        bus.clear_err = c;
        @(posedge clk);
        #1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.data_in   = 8'h00;
        bus.clear_err = 1'b0;
    endtask

    initial begin
        vectorCount   = 0;
        missCount     = 0;
        reset         = 1'b0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.data_in   = 8'h00;
        bus.clear_err = 1'b0;
        #23;
        checkOutput("rst_tos",   bus.tos, 8'h00);
        checkOutput("rst_nos",   bus.nos, 8'h00);
        checkOutput("rst_count", bus.count, 5'd0);
        checkOutput("rst_empty", bus.empty, 1'b1);
        checkOutput("rst_full",  bus.full, 1'b0);
        checkOutput("rst_flags", {bus.overflow, bus.underflow, bus.fault}, 3'b000);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(1, 0, 8'h11, 0);
        applyStimulus(1, 0, 8'h22, 0);
        applyStimulus(1, 0, 8'h33, 0);
        checkOutput("p3_count", bus.count, 5'd3);
        checkOutput("p3_tos",   bus.tos, 8'h33);
        checkOutput("p3_nos",   bus.nos, 8'h22);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("pop1_tos", bus.tos, 8'h22);
        checkOutput("pop1_nos", bus.nos, 8'h11);
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("pop3_empty", bus.empty, 1'b1);
        checkOutput("pop3_tos",   bus.tos, 8'h00);
        checkOutput("pop3_flags", {bus.overflow, bus.underflow, bus.fault}, 3'b000);

        applyStimulus(1, 0, 8'h05, 0);
        applyStimulus(1, 0, 8'h03, 0);
        applyStimulus(1, 1, 8'h08, 0);
        checkOutput("repl_count", bus.count, 5'd2);
        checkOutput("repl_tos",   bus.tos, 8'h08);
        checkOutput("repl_nos",   bus.nos, 8'h05);
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("repl_drain", bus.count, 5'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 8'(i), 0);
        end
        checkOutput("fill_full",  bus.full, 1'b1);
        checkOutput("fill_count", bus.count, 5'd16);
        checkOutput("fill_tos",   bus.tos, 8'h0F);
        checkOutput("fill_nos",   bus.nos, 8'h0E);
        applyStimulus(1, 0, 8'hAA, 0);
        checkOutput("ovf_flag",  bus.overflow, 1'b1);
        checkOutput("ovf_fault", bus.fault, 1'b1);
        checkOutput("ovf_unf",   bus.underflow, 1'b0);
        checkOutput("ovf_tos",   bus.tos, 8'h0F);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("fault_pop_count", bus.count, 5'd16);
        checkOutput("fault_pop_fault", bus.fault, 1'b1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("clr_fault", bus.fault, 1'b0);
        checkOutput("clr_ovf",   bus.overflow, 1'b0);
        checkOutput("clr_count", bus.count, 5'd16);
        checkOutput("clr_tos",   bus.tos, 8'h0F);

        applyStimulus(1, 1, 8'h77, 0);
        checkOutput("fullrepl_fault", bus.fault, 1'b0);
        checkOutput("fullrepl_tos",   bus.tos, 8'h77);
        checkOutput("fullrepl_nos",   bus.nos, 8'h0E);
        checkOutput("fullrepl_count", bus.count, 5'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 8'h00, 0);
        end
        checkOutput("drain_count", bus.count, 5'd0);
        checkOutput("drain_empty", bus.empty, 1'b1);

        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("unf_flag",  bus.underflow, 1'b1);
        checkOutput("unf_fault", bus.fault, 1'b1);
        checkOutput("unf_count", bus.count, 5'd0);
        applyStimulus(1, 0, 8'h44, 1);
        checkOutput("clrpush_count", bus.count, 5'd0);
        checkOutput("clrpush_flags", {bus.overflow, bus.underflow, bus.fault}, 3'b000);
        checkOutput("clrpush_tos",   bus.tos, 8'h00);

        applyStimulus(1, 1, 8'h55, 0);
        checkOutput("erepl_unf",   bus.underflow, 1'b1);
        checkOutput("erepl_fault", bus.fault, 1'b1);
        checkOutput("erepl_count", bus.count, 5'd0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("erepl_clr", bus.fault, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 0, 8'(i), 0);
        end
        checkOutput("pre_rst_count", bus.count, 5'd5);
        checkOutput("pre_rst_tos",   bus.tos, 8'h05);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_count", bus.count, 5'd0);
        checkOutput("arst_tos",   bus.tos, 8'h00);
        checkOutput("arst_nos",   bus.nos, 8'h00);
        checkOutput("arst_empty", bus.empty, 1'b1);
        checkOutput("arst_flags", {bus.full, bus.overflow, bus.underflow, bus.fault}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 0, 8'h99, 0);
        checkOutput("post_rst_tos",   bus.tos, 8'h99);
        checkOutput("post_rst_count", bus.count, 5'd1);
        applyStimulus(1, 0, 8'h9A, 0);
        checkOutput("post_rst_nos",   bus.nos, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
# operand_stack

Hardware LIFO operand stack for the 8-bit stack-machine CPU. It sits directly downstream of the CPU control unit and consumes its push/pop strobes and data-to-push byte. It returns the top-of-stack and next-on-stack words that feed the ALU operand registers and the POP-to-RAM path. A small fault FSM latches overflow/underflow and freezes the stack until software-visible clear.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of entries; must be ≥2
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridden)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- push  in  1  push data_in this cycle
- pop  in  1  pop top entry this cycle
- data_in  in  WIDTH  word to push (control's data_to_push)
- clear_err  in  1  leave FAULT, clear sticky error flags
- tos  out  WIDTH  top-of-stack word; 0 when count=0
- nos  out  WIDTH  next-on-stack word; 0 when count<2
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty
- fault  out  1  FSM is in FAULT

## Operation
- Storage: DEPTH×WIDTH register array plus stack pointer sp (= count). Entry sp-1 is TOS; entry sp-2 is NOS.
- FSM states: NORMAL, FAULT. Reset enters NORMAL.
- NORMAL, per cycle, decoded from {push,pop}:
  - 00: hold.
  - 10 push: if !full, write data_in to mem[sp] and set sp+1. If full, write nothing, set overflow, go to FAULT.
  - 01 pop: if !empty, set sp−1; the entry is not cleared. If empty, set underflow, go to FAULT.
  - 11 replace: if !empty, write data_in to mem[sp−1] and leave sp unchanged. This is the ALU write-back path and is legal when full. If empty, set underflow, go to FAULT.
- FAULT:
  - push and pop are ignored; contents, sp, and flags are held.
  - clear_err=1 returns to NORMAL, clears overflow and underflow, and keeps the contents.
- clear_err in NORMAL has no effect. clear_err takes priority over any op in the same cycle, and that op is dropped.
- tos, nos, empty, full, and count are combinational decodes of registered sp/mem. Each is 0 (or empty=1) when its entry does not exist.
- sp arithmetic: sp never wraps. Saturation is enforced by the full/empty checks above.

## Timing
- Reset (reset=0, async): sp=0, all mem=0, state=NORMAL. Outputs: tos=0, nos=0, count=0, empty=1, full=0, overflow=0, underflow=0, fault=0.
- Reset deassertion is synchronised by the system reset bridge. This block needs no internal synchroniser.
- Latency: an op sampled at edge N is reflected on tos/nos/count right after edge N, i.e. readable in cycle N+1. Throughput is one op per cycle with no stall.
- Back-to-back push then pop returns the just-pushed word on tos before the pop edge.
- Errors: overflow/underflow and fault assert in the cycle after the offending edge.
- Reset mid-operation aborts any op and clears contents immediately, without waiting for a clock.

## Structure
- Shared package stack_pkg:
  - STACK_WIDTH (8) and STACK_DEPTH (16) defaults.
  - stack_state_t enum {ST_NORMAL, ST_FAULT}.
  - Op decode localparams OP_HOLD/OP_PUSH/OP_POP/OP_REPL for the {push,pop} pair.
- One natural sub-module, stack_regfile: the DEPTH×WIDTH array with async-low clear, one write port (addr, data, we) and two combinational read ports (TOS, NOS addresses).
- operand_stack owns sp, the FSM, flags, and the boundary checks.

## Test plan
- Reset then push 0x11, 0x22, 0x33 -> count=3, tos=0x33, nos=0x22; three pops -> empty=1, tos=0, no flags.
- Push 0x05, 0x03, then push+pop with data_in=0x08 -> count=1... no: count stays 2, tos=0x08, nos=0x05.
- Fill 16 entries (0x00..0x0F), 17th push of 0xAA -> overflow=1, fault=1, tos=0x0F; then pop ignored (count=16); clear_err -> fault=0, count=16.
- Pop on empty -> underflow=1, fault=1; clear_err asserted with push 0x44 in the same cycle -> push dropped, count=0, flags cleared.
- Push+pop on empty -> underflow=1, count=0; push+pop while full with 0x77 -> no fault, tos=0x77, count=16.
- Assert reset low between clock edges after 5 pushes -> all outputs at reset values immediately, before the next clk edge.
